aes_kat_sequencer: RTL and testbench

Known-answer self-test controller for the shared AES engine. On a start pulse it runs the six FIPS-197 vectors in a fixed order: encrypt and decrypt at each of the 128/192/256-bit key sizes. For each test it issues one operation to the engine over a start/done handshake, compares the 128-bit result with a built-in expected value and records pass/fail. It sits between the board controls and the engine, replacing the free-running mode mux. Its low result byte feeds the BCD/7-segment display path.

---
 rtl/aes_kat_sequencer.sv | 144 ++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_sequencer.sv
// rtl/aes_kat_sequencer.sv - AES known-answer self-test sequencer driving the shared engine
// Runs the six FIPS-197 vectors (enc/dec at 128/192/256-bit keys) and records pass/fail per test.
module aes_kat_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         core_start,
    output logic [1:0]   core_keysize,
    output logic         core_decrypt,
    output logic [127:0] core_text,
    input  logic         core_done,
    input  logic [127:0] core_result,
    output logic         busy,
    output logic         done,
    output logic [5:0]   pass_mask,
    output logic         all_pass,
    output logic [2:0]   test_idx,
    output logic [7:0]   disp_byte
);

    localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0] LAST_TEST = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic            timed_out;
    logic [127:0]    captured;
    logic            check_pass;
    logic [5:0]      mask_upd;

    // Even tests encrypt the plaintext; odd tests decrypt the preceding ciphertext.
    function automatic logic [127:0] kat_text(input logic [2:0] idx);
        case (idx)
            3'd1:    kat_text = CT_128;
            3'd3:    kat_text = CT_192;
            3'd5:    kat_text = CT_256;
            default: kat_text = PLAIN;
        endcase
    endfunction

    function automatic logic [127:0] kat_expected(input logic [2:0] idx);
        case (idx)
            3'd0:    kat_expected = CT_128;
            3'd2:    kat_expected = CT_192;
            3'd4:    kat_expected = CT_256;
            default: kat_expected = PLAIN;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state;
        check_pass = (captured == kat_expected(test_idx)) && !timed_out;
        mask_upd   = pass_mask | ({5'b0, check_pass} << test_idx);
        case (state)
            S_IDLE:   if (start) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT:   if (core_done || timer == TIMER_LAST) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (test_idx == LAST_TEST) ? S_FINISH : S_ISSUE;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            core_start   <= 1'b0;
            core_keysize <= 2'b00;
            core_decrypt <= 1'b0;
            core_text    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_mask    <= '0;
            all_pass     <= 1'b0;
            test_idx     <= '0;
            disp_byte    <= '0;
            timer        <= '0;
            timed_out    <= 1'b0;
            captured     <= '0;
        end else begin
            state      <= state_nxt;
            core_start <= (state_nxt == S_ISSUE);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pass_mask    <= '0;
                        all_pass     <= 1'b0;
                        disp_byte    <= '0;
                        test_idx     <= '0;
                        core_keysize <= 2'b00;
                        core_decrypt <= 1'b0;
                        core_text    <= kat_text(3'd0);
                    end
                end
                S_ISSUE: begin
                    timer     <= '0;
                    timed_out <= 1'b0;
                end
                S_WAIT: begin
                    if (core_done) begin
                        captured <= core_result;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == TIMER_LAST) timed_out <= 1'b1;
                    end
                end
                S_CHECK: begin
                    pass_mask <= mask_upd;
                    disp_byte <= timed_out ? 8'h00 : captured[7:0];
                    if (test_idx == LAST_TEST) begin
                        all_pass <= &mask_upd;
                    end else begin
                        test_idx     <= test_idx + 3'd1;
                        core_keysize <= 2'((test_idx + 3'd1) >> 1);
                        core_decrypt <= ~test_idx[0];
                        core_text    <= kat_text(test_idx + 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// tb/tb_aes_kat_sequencer.sv - scoreboard bench for aes_kat_sequencer with a behavioural engine
module tb_aes_kat_sequencer;

    localparam int TIMEOUT = 64;
    localparam int LAT     = 12;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         core_start;
    logic [1:0]   core_keysize;
    logic         core_decrypt;
    logic [127:0] core_text;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy;
    logic         done;
    logic [5:0]   pass_mask;
    logic         all_pass;
    logic [2:0]   test_idx;
    logic [7:0]   disp_byte;

    aes_kat_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .core_start   (core_start),
        .core_keysize (core_keysize),
        .core_decrypt (core_decrypt),
        .core_text    (core_text),
        .core_done    (core_done),
        .core_result  (core_result),
        .busy         (busy),
        .done         (done),
        .pass_mask    (pass_mask),
        .all_pass     (all_pass),
        .test_idx     (test_idx),
        .disp_byte    (disp_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cyc;
        logic [1:0]   ks;
        logic         dec;
        logic [127:0] text;
    } iss_t;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
        logic       ap;
        logic [7:0] disp;
    } fin_t;

    iss_t iss_q[$];
    fin_t fin_q[$];
    iss_t mon_i;
    fin_t mon_f;

    int corrupt_idx = -1;
    int hang_idx    = -1;
    bit spurious    = 1'b0;
    int last_t      = 0;

    function automatic logic [127:0] tb_text(input int i);
        case (i)
            1:       return C128;
            3:       return C192;
            5:       return C256;
            default: return PT;
        endcase
    endfunction

    function automatic logic [127:0] tb_exp(input int i);
        case (i)
            0:       return C128;
            2:       return C192;
            4:       return C256;
            default: return PT;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Engine model: answers L cycles after core_start, optionally corrupting, hanging or glitching.
    initial begin
        int eidx;
        int ek;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start && !reset) begin
                eidx = int'(core_keysize) * 2 + int'(core_decrypt);
                ek   = LAT;
                if (spurious && eidx == 0) begin
                    core_done   = 1'b1;
                    core_result = '1;
                    @(negedge clk);
                    core_done = 1'b0;
                    ek = LAT - 1;
                end
                if (eidx != hang_idx) begin
                    repeat (ek) @(negedge clk);
                    core_done   = 1'b1;
                    core_result = tb_exp(eidx) ^ {127'b0, (eidx == corrupt_idx)};
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && core_start) begin
            checks++;
            if (iss_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_core_start cycle=%0d", cyc);
            end else begin
                mon_i = iss_q.pop_front();
                if (cyc != mon_i.cyc || core_keysize !== mon_i.ks || core_decrypt !== mon_i.dec ||
                    core_text !== mon_i.text || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL issue actual cyc=%0d ks=%0d dec=%0d text=%h busy=%0d expected cyc=%0d ks=%0d dec=%0d text=%h",
                             cyc, core_keysize, core_decrypt, core_text, busy,
                             mon_i.cyc, mon_i.ks, mon_i.dec, mon_i.text);
                end
            end
        end
        if (!reset && done) begin
            checks++;
            if (fin_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cycle=%0d", cyc);
            end else begin
                mon_f = fin_q.pop_front();
                if (cyc != mon_f.cyc || pass_mask !== mon_f.mask || all_pass !== mon_f.ap ||
                    disp_byte !== mon_f.disp) begin
                    errors++;
                    $display("FAIL finish actual cyc=%0d mask=%b all=%0d disp=%h expected cyc=%0d mask=%b all=%0d disp=%h",
                             cyc, pass_mask, all_pass, disp_byte,
                             mon_f.cyc, mon_f.mask, mon_f.ap, mon_f.disp);
                end
            end
        end
    end

    // Expected issue/done cycles: CHECK is L+1 cycles after ISSUE, or TIMEOUT+1 when the engine hangs.
    task automatic start_sweep(input int hang, input logic [5:0] mask, input logic [7:0] disp);
        int issue;
        int chk;
        @(negedge clk);
        start  = 1'b1;
        last_t = cyc;
        issue  = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            iss_q.push_back('{issue, 2'(i / 2), 1'(i % 2), tb_text(i)});
            chk   = issue + 1 + ((i == hang) ? TIMEOUT : LAT);
            issue = chk + 1;
        end
        fin_q.push_back('{issue, mask, &mask, disp});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        while (fin_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completed"}, 128'(fin_q.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start_at(input int c);
        while (cyc < c) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_cleared(input string name);
        check({name, "_ctrl"}, 128'({core_start, busy, done, core_keysize, core_decrypt,
                                     pass_mask, all_pass, test_idx, disp_byte}), 128'd0);
        check({name, "_text"}, core_text, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_cleared("post_reset");

        start_sweep(-1, 6'b111111, 8'hff);
        wait_sweep("ideal");
        check("ideal_hold", 128'({busy, pass_mask, all_pass, disp_byte}), 128'({1'b0, 6'b111111, 1'b1, 8'hff}));

        corrupt_idx = 2;
        start_sweep(-1, 6'b111011, 8'hff);
        wait_sweep("corrupt2");
        corrupt_idx = -1;

        hang_idx = 4;
        start_sweep(4, 6'b101111, 8'hff);
        wait_sweep("hang4");
        hang_idx = -1;

        start_sweep(-1, 6'b111111, 8'hff);
        while (cyc < last_t + 48) @(negedge clk);
        reset = 1'b1;
        #1;
        check_cleared("midsweep_reset");
        iss_q.delete();
        fin_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_cleared("after_reset_idle");
        start_sweep(-1, 6'b111111, 8'hff);
        wait_sweep("rerun");

        spurious = 1'b1;
        start_sweep(-1, 6'b111111, 8'hff);
        pulse_start_at(last_t + 20);
        pulse_start_at(last_t + 50);
        pulse_start_at(last_t + 85);
        repeat (40) @(negedge clk);
        spurious = 1'b0;
        check("spurious_done_consumed", 128'(fin_q.size()), 128'd0);
        check("spurious_hold", 128'({busy, pass_mask, all_pass, disp_byte}), 128'({1'b0, 6'b111111, 1'b1, 8'hff}));

        check("issue_queue_empty", 128'(iss_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
